// File: rtl/traffic_light_ctrl.sv
// Two-road (NS/EW) traffic-light sequencer advanced by a one-cycle tick enable.
// Optional night flashing mode is compiled in with `define NIGHT_MODE_EN.
module traffic_light_ctrl #(
  parameter int T_GREEN_NS = 25,
  parameter int T_GREEN_EW = 20,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 2,
  parameter int CNT_W      = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             hold,
  input  logic             night,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] countdown,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    ST_AR_NS = 3'd0,
    ST_NS_G  = 3'd1,
    ST_NS_Y  = 3'd2,
    ST_AR_EW = 3'd3,
    ST_EW_G  = 3'd4,
    ST_EW_Y  = 3'd5,
    ST_FLASH = 3'd6
  } state_e;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_ns;
  logic [2:0]       r_ew;
  logic [2:0]       w_next;
  logic             w_qual;
  logic             w_legal;

  function automatic logic [2:0] f_next(input logic [2:0] s);
    case (s)
      ST_AR_NS: f_next = ST_NS_G;
      ST_NS_G:  f_next = ST_NS_Y;
      ST_NS_Y:  f_next = ST_AR_EW;
      ST_AR_EW: f_next = ST_EW_G;
      ST_EW_G:  f_next = ST_EW_Y;
      default:  f_next = ST_AR_NS;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] f_dur(input logic [2:0] s);
    case (s)
      ST_NS_G:          f_dur = CNT_W'(T_GREEN_NS);
      ST_EW_G:          f_dur = CNT_W'(T_GREEN_EW);
      ST_NS_Y, ST_EW_Y: f_dur = CNT_W'(T_YELLOW);
      default:          f_dur = CNT_W'(T_ALLRED);
    endcase
  endfunction

  function automatic logic [2:0] f_ns(input logic [2:0] s);
    case (s)
      ST_NS_G: f_ns = L_GRN;
      ST_NS_Y: f_ns = L_YEL;
      default: f_ns = L_RED;
    endcase
  endfunction

  function automatic logic [2:0] f_ew(input logic [2:0] s);
    case (s)
      ST_EW_G: f_ew = L_GRN;
      ST_EW_Y: f_ew = L_YEL;
      default: f_ew = L_RED;
    endcase
  endfunction

  assign w_next  = f_next(r_state);
  assign w_qual  = tick & ~hold;
  assign w_legal = (r_state <= 3'(ST_EW_Y));

`ifndef NIGHT_MODE_EN
  logic w_unused_night;
  assign w_unused_night = night;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_AR_NS;
      r_cnt   <= CNT_W'(T_ALLRED);
      r_ns    <= L_RED;
      r_ew    <= L_RED;
    end else if (w_legal) begin
      if (w_qual) begin
`ifdef NIGHT_MODE_EN
        if (night) begin
          r_state <= ST_FLASH;
          r_cnt   <= '0;
          r_ns    <= L_YEL;
          r_ew    <= L_YEL;
        end else
`endif
        if (r_cnt > CNT_W'(1)) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end else begin
          // Phase boundary: next state, its duration and lamps load together.
          r_state <= w_next;
          r_cnt   <= f_dur(w_next);
          r_ns    <= f_ns(w_next);
          r_ew    <= f_ew(w_next);
        end
      end
`ifdef NIGHT_MODE_EN
    end else if (r_state == 3'(ST_FLASH)) begin
      if (w_qual) begin
        if (night) begin
          r_ns <= r_ns ^ L_YEL;
          r_ew <= r_ew ^ L_YEL;
        end else begin
          r_state <= ST_AR_NS;
          r_cnt   <= CNT_W'(T_ALLRED);
          r_ns    <= L_RED;
          r_ew    <= L_RED;
        end
      end
`endif
    end else begin
      // Unreachable encoding: fall back to the all-red start regardless of tick.
      r_state <= ST_AR_NS;
      r_cnt   <= CNT_W'(T_ALLRED);
      r_ns    <= L_RED;
      r_ew    <= L_RED;
    end
  end

  assign ns_light  = r_ns;
  assign ew_light  = r_ew;
  assign countdown = r_cnt;
  assign phase     = r_state;

endmodule
